// File: rtl/ras_pkg.sv
// Shared types and defaults for the return-address stack.
// Optional build macro: RAS_CIRCULAR_EN (push while full overwrites the oldest entry).
package ras_pkg;

  localparam int RAS_DEPTH  = 8;
  localparam int RAS_ADDR_W = 32;
  localparam int CNT_W      = $clog2(RAS_DEPTH) + 1;

  // Encoding matches {Push, Pop} so decode is a plain cast.
  typedef enum logic [1:0] {
    RAS_NOP     = 2'b00,
    RAS_POP     = 2'b01,
    RAS_PUSH    = 2'b10,
    RAS_REPLACE = 2'b11
  } ras_op_e;

endpackage

// File: rtl/ras_storage.sv
// DEPTH x ADDR_W register array: one synchronous write port, one combinational read port.
// No reset; contents are only meaningful below the owner's top pointer.
module ras_storage #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [ADDR_W-1:0] rd_data
);

  logic [DEPTH-1:0][ADDR_W-1:0] mem;

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack feeding the PC mux; pointer, count and sticky flags live here.
// Optional build macro: RAS_CIRCULAR_EN (push while full overwrites the oldest entry).
module return_address_stack
  import ras_pkg::*;
#(
  parameter int DEPTH      = RAS_DEPTH,
  parameter int ADDR_W     = RAS_ADDR_W,
  parameter int RET_OFFSET = 1
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic [ADDR_W-1:0]      PushAddr,
  input  logic                   ClearFlags,
  output logic [ADDR_W-1:0]      RA,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Empty,
  output logic                   Full,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  ras_op_e           op;
  logic [PTR_W-1:0]  top, top_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic [ADDR_W-1:0] ra_nxt, new_val, rd_data, wr_addr_unused_guard;
  logic [PTR_W-1:0]  wr_addr, rd_addr;
  logic              wr_en, ovf_nxt, unf_nxt;

  assign op      = ras_op_e'({Push, Pop});
  assign new_val = PushAddr + ADDR_W'(RET_OFFSET);
  // After a pop the new top sits two slots below the write pointer.
  assign rd_addr = top - PTR_W'(2);
  assign wr_addr_unused_guard = '0;

  always_comb begin
    top_nxt = top;
    cnt_nxt = Count;
    ra_nxt  = RA;
    ovf_nxt = Overflow & ~ClearFlags;
    unf_nxt = Underflow & ~ClearFlags;
    wr_en   = 1'b0;
    wr_addr = top;
    unique case (op)
      RAS_PUSH: begin
        if (!Full) begin
          wr_en   = 1'b1;
          top_nxt = top + PTR_W'(1);
          cnt_nxt = Count + CW'(1);
          ra_nxt  = new_val;
        end else begin
          ovf_nxt = 1'b1;
`ifdef RAS_CIRCULAR_EN
          // When full, slot[top] holds the oldest entry; overwrite it.
          wr_en   = 1'b1;
          top_nxt = top + PTR_W'(1);
          ra_nxt  = new_val;
`endif
        end
      end
      RAS_POP: begin
        if (!Empty) begin
          top_nxt = top - PTR_W'(1);
          cnt_nxt = Count - CW'(1);
          ra_nxt  = (Count == CW'(1)) ? wr_addr_unused_guard : rd_data;
        end else begin
          unf_nxt = 1'b1;
        end
      end
      RAS_REPLACE: begin
        wr_en  = 1'b1;
        ra_nxt = new_val;
        if (Empty) begin
          top_nxt = top + PTR_W'(1);
          cnt_nxt = Count + CW'(1);
        end else begin
          wr_addr = top - PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      top       <= '0;
      Count     <= '0;
      RA        <= '0;
      Empty     <= 1'b1;
      Full      <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      top       <= top_nxt;
      Count     <= cnt_nxt;
      RA        <= ra_nxt;
      Empty     <= (cnt_nxt == '0);
      Full      <= (cnt_nxt == CW'(DEPTH));
      Overflow  <= ovf_nxt;
      Underflow <= unf_nxt;
    end
  end

  ras_storage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_storage (
    .Clock   (Clock),
    .wr_en   (wr_en & Reset_n),
    .wr_addr (wr_addr),
    .wr_data (new_val),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
